// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register-file
// constants, the NOP encoding and the hazard-sequencer state type.
package mips_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment),
// used for the hazard performance counters.
module hazard_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline (load-use, taken branch,
// MDU occupancy, data-memory wait). Perf counters gated by HAZARD_PERF_CNT_EN.
module pipeline_hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  id_uses_mdu,
    input  logic                  ex_mdu_start,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_freeze,
    output logic                  mdu_busy,
    input  logic                  perf_clr,
    output logic [15:0]           perf_lu_cnt,
    output logic [15:0]           perf_mdu_cnt,
    output logic [15:0]           perf_flush_cnt
);

    localparam logic [CNT_W-1:0] MDU_START_CNT = CNT_W'(MDU_LATENCY - 1);

    hazard_state_t    state, state_next;
    logic [CNT_W-1:0] mdu_cnt, cnt_next;
    logic             load_use, mdu_hz;

    assign load_use = id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
                      ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    assign mdu_hz   = (state == MDU_BUSY) && id_uses_mdu;
    assign mdu_busy = (state == MDU_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            mdu_cnt <= '0;
        end else begin
            state   <= state_next;
            mdu_cnt <= cnt_next;
        end
    end

    // A data-memory wait freezes the MDU together with the rest of the pipe.
    always_comb begin
        state_next = state;
        cnt_next   = mdu_cnt;
        if (dmem_ready) begin
            case (state)
                RUN: begin
                    if (ex_mdu_start) begin
                        state_next = MDU_BUSY;
                        cnt_next   = MDU_START_CNT;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt == '0) begin
                        state_next = RUN;
                    end else begin
                        cnt_next = mdu_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (!dmem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use || mdu_hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    a_no_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_mdu_start && dmem_ready && (state == MDU_BUSY)));
    a_no_start_with_branch: assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_mdu_start && ex_branch_taken));

`ifdef HAZARD_PERF_CNT_EN
    logic lu_stall, mdu_stall;

    assign lu_stall  = dmem_ready && !ex_branch_taken && load_use;
    assign mdu_stall = dmem_ready && !ex_branch_taken && mdu_hz;

    hazard_sat_counter #(.W(16)) u_lu_cnt (
        .clk(clk), .rst_n(rst_n), .en(lu_stall), .clr(perf_clr), .count(perf_lu_cnt)
    );
    hazard_sat_counter #(.W(16)) u_mdu_cnt (
        .clk(clk), .rst_n(rst_n), .en(mdu_stall), .clr(perf_clr), .count(perf_mdu_cnt)
    );
    hazard_sat_counter #(.W(16)) u_flush_cnt (
        .clk(clk), .rst_n(rst_n), .en(if_id_flush), .clr(perf_clr), .count(perf_flush_cnt)
    );
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr;
    assign perf_lu_cnt     = '0;
    assign perf_mdu_cnt    = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; outputs are compared as the
// packed vector {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mdu_busy}.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
    logic        if_id_uses_rt, id_uses_mdu, ex_mdu_start, ex_branch_taken, dmem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mdu_busy;
    logic        perf_clr;
    logic [15:0] perf_lu_cnt, perf_mdu_cnt, perf_flush_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [5:0] O_RUN    = 6'b110000;
    localparam logic [5:0] O_STALL  = 6'b000100;
    localparam logic [5:0] O_FREEZE = 6'b000010;
    localparam logic [5:0] O_FLUSH  = 6'b111100;
    localparam logic [5:0] O_RESET  = 6'b000100;
    localparam logic [5:0] BUSY     = 6'b000001;

    logic [5:0] outs;
    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mdu_busy};

    pipeline_hazard_controller #(.MDU_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_uses_mdu(id_uses_mdu), .ex_mdu_start(ex_mdu_start),
        .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .mdu_busy(mdu_busy),
        .perf_clr(perf_clr), .perf_lu_cnt(perf_lu_cnt), .perf_mdu_cnt(perf_mdu_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_ex_mem_read  = 1'b0;
        id_ex_rt        = 5'd0;
        if_id_rs        = 5'd0;
        if_id_rt        = 5'd0;
        if_id_uses_rt   = 1'b0;
        id_uses_mdu     = 1'b0;
        ex_mdu_start    = 1'b0;
        ex_branch_taken = 1'b0;
        dmem_ready      = 1'b1;
        perf_clr        = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (outs !== O_RESET) $display("FAIL reset_outs: got %b expected %b", outs, O_RESET);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL reset_release_run: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; if_id_rt = 5'd9;
        #1;
        total_cnt++;
        if (outs !== O_STALL) $display("FAIL load_use_rs: got %b expected %b", outs, O_STALL);
        else pass_cnt++;
        step();
        // bubble moved the load to MEM; EX now holds the NOP
        id_ex_mem_read = 1'b0;
        #1;
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL load_use_release: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd3; if_id_rt = 5'd8; if_id_uses_rt = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_STALL) $display("FAIL load_use_rt: got %b expected %b", outs, O_STALL);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
    endtask

    task automatic test_no_stall();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL r0_no_stall: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
        id_ex_rt = 5'd8; if_id_rs = 5'd4; if_id_rt = 5'd8; if_id_uses_rt = 1'b0;
        #1;
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL rt_unused_no_stall: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
        id_ex_mem_read = 1'b0; id_ex_rt = 5'd8; if_id_rs = 5'd8;
        #1;
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL non_load_no_stall: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
        idle_inputs();
        #1;
    endtask

    task automatic test_mdu();
        ex_mdu_start = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL mdu_start_cycle: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
        step();
        ex_mdu_start = 1'b0; id_uses_mdu = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (outs !== (O_STALL | BUSY))
                $display("FAIL mdu_stall_%0d: got %b expected %b", i, outs, O_STALL | BUSY);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL mdu_release: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
        // a non-MDU instruction in ID flows freely while the MDU is busy
        idle_inputs();
        ex_mdu_start = 1'b1;
        step();
        ex_mdu_start = 1'b0;
        #1;
        total_cnt++;
        if (outs !== (O_RUN | BUSY)) $display("FAIL mdu_add_flows: got %b expected %b", outs, O_RUN | BUSY);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) step();
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL mdu_idle_end: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
    endtask

    task automatic test_mdu_freeze();
        ex_mdu_start = 1'b1;
        step();
        ex_mdu_start = 1'b0; id_uses_mdu = 1'b1;
        #1;
        total_cnt++;
        if (outs !== (O_STALL | BUSY)) $display("FAIL frz_pre: got %b expected %b", outs, O_STALL | BUSY);
        else pass_cnt++;
        step();
        dmem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (outs !== (O_FREEZE | BUSY))
                $display("FAIL frz_hold_%0d: got %b expected %b", i, outs, O_FREEZE | BUSY);
            else pass_cnt++;
            step();
        end
        dmem_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (outs !== (O_STALL | BUSY))
                $display("FAIL frz_post_%0d: got %b expected %b", i, outs, O_STALL | BUSY);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL frz_release: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
        idle_inputs();
        #1;
    endtask

    task automatic test_branch();
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; ex_branch_taken = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_FLUSH) $display("FAIL branch_over_lu: got %b expected %b", outs, O_FLUSH);
        else pass_cnt++;
        dmem_ready = 1'b0;
        #1;
        total_cnt++;
        if (outs !== O_FREEZE) $display("FAIL branch_frozen: got %b expected %b", outs, O_FREEZE);
        else pass_cnt++;
        step();
        idle_inputs();
        #1;
    endtask

    task automatic test_reset_mid_mdu();
        ex_mdu_start = 1'b1;
        step();
        ex_mdu_start = 1'b0;
        step();
        total_cnt++;
        if (outs !== (O_RUN | BUSY)) $display("FAIL rst_mid_busy: got %b expected %b", outs, O_RUN | BUSY);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (outs !== O_RESET) $display("FAIL rst_mid_outs: got %b expected %b", outs, O_RESET);
        else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
        total_cnt++;
        if ({perf_lu_cnt, perf_mdu_cnt, perf_flush_cnt} !== 48'd0)
            $display("FAIL rst_perf_zero: got %h/%h/%h expected 0/0/0", perf_lu_cnt, perf_mdu_cnt, perf_flush_cnt);
        else pass_cnt++;
`endif
        step();
        rst_n = 1'b1;
        id_uses_mdu = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_RUN) $display("FAIL rst_mid_run: got %b expected %b", outs, O_RUN);
        else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_mdu();
        test_mdu_freeze();
        test_branch();
        test_reset_mid_mdu();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
